// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one serializer between CH_NUM requesters.
// Optional macro SER_ARB_SKIP_IGNORED_EN drops ignored-mod requests locally instead of forwarding them.
module serializer_arbiter #(
  parameter int CH_NUM        = 4,
  parameter int DATA_W        = 16,
  parameter int MOD_W         = $clog2(DATA_W),
  parameter int CH_W          = $clog2(CH_NUM),
  parameter int MOD_IGNORE_LO = 1,
  parameter int MOD_IGNORE_HI = 2
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [CH_NUM-1:0]          req_val_i,
  input  logic [CH_NUM*DATA_W-1:0]   req_data_i,
  input  logic [CH_NUM*MOD_W-1:0]    req_mod_i,
  output logic [CH_NUM-1:0]          req_ready_o,
  output logic [DATA_W-1:0]          ser_data_o,
  output logic [MOD_W-1:0]           ser_mod_o,
  output logic                       ser_val_o,
  input  logic                       ser_busy_i,
  output logic [CH_W-1:0]            grant_id_o,
  output logic                       grant_val_o,
  output logic                       skip_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   ser_data_q, ser_data_d;
  logic [MOD_W-1:0]    ser_mod_q, ser_mod_d;
  logic [CH_NUM-1:0]   req_ready_q, req_ready_d;
  logic                ser_val_q, ser_val_d;
  logic                grant_val_q, grant_val_d;

  logic [CH_NUM-1:0]   req_eff;
  logic                sel_found;
  logic [CH_W-1:0]     sel_id;
  logic [DATA_W-1:0]   sel_data;
  logic [MOD_W-1:0]    sel_mod;
  logic                accept;
  logic                forward;

`ifdef SER_ARB_SKIP_IGNORED_EN
  localparam logic [MOD_W-1:0] IGN_LO = MOD_W'(MOD_IGNORE_LO);
  localparam logic [MOD_W-1:0] IGN_HI = MOD_W'(MOD_IGNORE_HI);
  logic skip_q, skip_d;
`endif

  // A channel being acknowledged this cycle still shows its old request; mask it out.
  always_comb begin
    req_eff   = req_val_i & ~req_ready_q;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!sel_found && req_eff[(int'(rr_ptr_q) + i) % CH_NUM]) begin
        sel_found = 1'b1;
        sel_id    = CH_W'((int'(rr_ptr_q) + i) % CH_NUM);
      end
    end
    sel_data = req_data_i[int'(sel_id)*DATA_W +: DATA_W];
    sel_mod  = req_mod_i[int'(sel_id)*MOD_W +: MOD_W];
    accept   = (state_q == IDLE) && sel_found;
`ifdef SER_ARB_SKIP_IGNORED_EN
    forward  = !((sel_mod >= IGN_LO) && (sel_mod <= IGN_HI));
`else
    forward  = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && forward) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = DRAIN;
      DRAIN:   if (!ser_busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    ser_data_d  = ser_data_q;
    ser_mod_d   = ser_mod_q;
    req_ready_d = '0;
    ser_val_d   = (state_d == ISSUE);
    grant_val_d = (state_d != IDLE);
`ifdef SER_ARB_SKIP_IGNORED_EN
    skip_d      = 1'b0;
`endif
    if (accept) begin
      req_ready_d = CH_NUM'(1) << sel_id;
      rr_ptr_d    = sel_id;
      if (forward) begin
        grant_id_d = sel_id;
        ser_data_d = sel_data;
        ser_mod_d  = sel_mod;
      end
`ifdef SER_ARB_SKIP_IGNORED_EN
      else begin
        skip_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr_ptr_q    <= CH_W'(CH_NUM - 1);
      grant_id_q  <= '0;
      ser_data_q  <= '0;
      ser_mod_q   <= '0;
      req_ready_q <= '0;
      ser_val_q   <= 1'b0;
      grant_val_q <= 1'b0;
`ifdef SER_ARB_SKIP_IGNORED_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      ser_data_q  <= ser_data_d;
      ser_mod_q   <= ser_mod_d;
      req_ready_q <= req_ready_d;
      ser_val_q   <= ser_val_d;
      grant_val_q <= grant_val_d;
`ifdef SER_ARB_SKIP_IGNORED_EN
      skip_q      <= skip_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign ser_data_o  = ser_data_q;
  assign ser_mod_o   = ser_mod_q;
  assign ser_val_o   = ser_val_q;
  assign grant_id_o  = grant_id_q;
  assign grant_val_o = grant_val_q;
`ifdef SER_ARB_SKIP_IGNORED_EN
  assign skip_o      = skip_q;
`else
  assign skip_o      = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: drives it with a behavioural serializer model and
// per-channel requesters that hold their request until the ready pulse.
module tb_serializer_arbiter;
  localparam int CH_NUM = 4;
  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     srst_i;
  logic [CH_NUM-1:0]        req_val_i;
  logic [CH_NUM*DATA_W-1:0] req_data_i;
  logic [CH_NUM*MOD_W-1:0]  req_mod_i;
  logic [CH_NUM-1:0]        req_ready_o;
  logic [DATA_W-1:0]        ser_data_o;
  logic [MOD_W-1:0]         ser_mod_o;
  logic                     ser_val_o;
  logic                     ser_busy_i;
  logic [CH_W-1:0]          grant_id_o;
  logic                     grant_val_o;
  logic                     skip_o;

  always #5 clk = ~clk;

  serializer_arbiter #(.CH_NUM(CH_NUM), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .srst_i(srst_i), .req_val_i(req_val_i), .req_data_i(req_data_i),
    .req_mod_i(req_mod_i), .req_ready_o(req_ready_o), .ser_data_o(ser_data_o),
    .ser_mod_o(ser_mod_o), .ser_val_o(ser_val_o), .ser_busy_i(ser_busy_i),
    .grant_id_o(grant_id_o), .grant_val_o(grant_val_o), .skip_o(skip_o)
  );

  typedef struct { logic [15:0] word; int n; } ser_t;
  typedef struct { logic [3:0] add_mask; logic [3:0] exp_ready; logic [1:0] exp_id; } vec_t;

  int checks = 0;
  int errors = 0;
  ser_t exp_q[$];
  ser_t got_q[$];
  logic        m_busy = 1'b0;
  logic [15:0] m_sh, m_acc;
  int          m_cnt, m_n;
  int          busy_cycles = 0;
  int          accepts = 0;
  logic [1:0]  rr_m = 2'd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] pend, input logic [1:0] rr);
    for (int i = 1; i <= 4; i++) begin
      int idx = (int'(rr) + i) % 4;
      if (pend[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  // One clock cycle: serializer model, requester release and accept bookkeeping.
  task automatic tick();
    logic v; logic [15:0] d; logic [3:0] m; logic rst; logic [3:0] pend;
    v = ser_val_o; d = ser_data_o; m = ser_mod_o; rst = srst_i; pend = req_val_i;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; rr_m = 2'd3;
    end else if (m_busy) begin
      m_acc = {m_acc[14:0], m_sh[15]};
      m_sh  = m_sh << 1;
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        got_q.push_back('{m_acc, m_n});
      end
    end else if (v && !(m == 4'd1 || m == 4'd2)) begin
      m_busy = 1'b1; m_sh = d; m_acc = '0;
      m_n = (m == 4'd0) ? 16 : int'(m);
      m_cnt = m_n;
    end
    ser_busy_i = m_busy;
    if (m_busy) busy_cycles++;
    if (!rst && req_ready_o != 4'b0000) begin
      accepts++;
      chk("rr_order", 32'(req_ready_o), 32'(rr_pick(pend, rr_m)));
      for (int c = 0; c < 4; c++) begin
        if (req_ready_o[c]) begin
          logic [15:0] w; logic [3:0] md; int n;
          w  = req_data_i[c*16 +: 16];
          md = req_mod_i[c*4 +: 4];
          n  = (md == 4'd0) ? 16 : int'(md);
          rr_m = 2'(c);
          if (!(md == 4'd1 || md == 4'd2)) exp_q.push_back('{w >> (16 - n), n});
          req_val_i[c] = 1'b0;
        end
      end
    end
    if (ser_val_o) chk("val_while_busy", 32'(ser_busy_i), 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_ready_o != 4'b0000) return;
    end
    checks++; errors++;
    $display("FAIL wait_ready: got timeout expected ready pulse");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (req_val_i == 4'b0000 && !grant_val_o && !ser_busy_i && !ser_val_o) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL wait_idle: got timeout expected idle");
  endtask

  task automatic wait_busy_drop();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ser_busy_i) seen = 1;
      if (seen && !ser_busy_i) return;
    end
    checks++; errors++;
    $display("FAIL wait_busy_drop: got timeout expected busy to fall");
  endtask

  task automatic raise(input int c, input logic [15:0] w, input logic [3:0] md);
    req_data_i[c*16 +: 16] = w;
    req_mod_i[c*4 +: 4]    = md;
    req_val_i[c]           = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 0);
    chk({tag, "_ser_val"}, 32'(ser_val_o), 0);
    chk({tag, "_ser_data"}, 32'(ser_data_o), 0);
    chk({tag, "_ser_mod"}, 32'(ser_mod_o), 0);
    chk({tag, "_grant_id"}, 32'(grant_id_o), 0);
    chk({tag, "_grant_val"}, 32'(grant_val_o), 0);
    chk({tag, "_skip"}, 32'(skip_o), 0);
  endtask

  vec_t tbl[10];

  initial begin
    ser_t g;
    int acc0;
    tbl[0] = '{4'b1111, 4'b0001, 2'd0};
    tbl[1] = '{4'b0000, 4'b0010, 2'd1};
    tbl[2] = '{4'b0000, 4'b0100, 2'd2};
    tbl[3] = '{4'b0000, 4'b1000, 2'd3};
    tbl[4] = '{4'b1010, 4'b0010, 2'd1};
    tbl[5] = '{4'b0000, 4'b1000, 2'd3};
    tbl[6] = '{4'b0101, 4'b0001, 2'd0};
    tbl[7] = '{4'b0000, 4'b0100, 2'd2};
    tbl[8] = '{4'b1001, 4'b1000, 2'd3};
    tbl[9] = '{4'b0000, 4'b0001, 2'd0};

    srst_i = 1'b1; req_val_i = '0; req_data_i = '0; req_mod_i = '0; ser_busy_i = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    srst_i = 1'b0;
    tick();

    // 1: single full-width word from ch0
    raise(0, 16'hAAAA, 4'd0);
    wait_ready();
    chk("t1_ready", 32'(req_ready_o), 32'h1);
    chk("t1_ser_val", 32'(ser_val_o), 1);
    chk("t1_ser_data", 32'(ser_data_o), 32'hAAAA);
    chk("t1_grant_val", 32'(grant_val_o), 1);
    busy_cycles = 0;
    tick();
    chk("t1_ser_val_pulse", 32'(ser_val_o), 0);
    chk("t1_ready_pulse", 32'(req_ready_o), 0);
    wait_busy_drop();
    chk("t1_busy_cycles", 32'(busy_cycles), 16);
    chk("t1_grant_hold", 32'(grant_val_o), 1);
    if (got_q.size() > 0) begin
      g = got_q[$];
      chk("t1_stream", 32'(g.word), 32'hAAAA);
    end else chk("t1_stream_cnt", 0, 1);
    tick();
    chk("t1_grant_drop", 32'(grant_val_o), 0);
    chk("t1_data_hold", 32'(ser_data_o), 32'hAAAA);

    // 2: round-robin table, starting from reset priority
    wait_idle();
    srst_i = 1'b1; tick(); srst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++)
        if (tbl[k].add_mask[c]) raise(c, 16'hC000 | 16'(k*16 + c), 4'd3);
      wait_ready();
      chk($sformatf("tbl%0d_ready", k), 32'(req_ready_o), 32'(tbl[k].exp_ready));
      chk($sformatf("tbl%0d_grant_id", k), 32'(grant_id_o), 32'(tbl[k].exp_id));
      chk($sformatf("tbl%0d_ser_val", k), 32'(ser_val_o), 1);
    end

    // 3: short word, mod 4
    wait_idle();
    raise(2, 16'hF0F0, 4'd4);
    wait_ready();
    chk("t3_ready", 32'(req_ready_o), 32'h4);
    chk("t3_mod", 32'(ser_mod_o), 4);
    busy_cycles = 0;
    wait_busy_drop();
    chk("t3_busy_cycles", 32'(busy_cycles), 4);
    if (got_q.size() > 0) begin
      g = got_q[$];
      chk("t3_stream", 32'(g.word), 32'hF);
      chk("t3_nbits", 32'(g.n), 4);
    end else chk("t3_stream_cnt", 0, 1);
    tick();
    chk("t3_released", 32'(grant_val_o), 0);

    // 4: ignored mod
    wait_idle();
    raise(1, 16'h1234, 4'd1);
    wait_ready();
    chk("t4_ready", 32'(req_ready_o), 32'h2);
`ifdef SER_ARB_SKIP_IGNORED_EN
    chk("t4_skip", 32'(skip_o), 1);
    chk("t4_ser_val", 32'(ser_val_o), 0);
    chk("t4_grant_val", 32'(grant_val_o), 0);
    tick();
    chk("t4_skip_pulse", 32'(skip_o), 0);
`else
    chk("t4_skip", 32'(skip_o), 0);
    chk("t4_ser_val", 32'(ser_val_o), 1);
    busy_cycles = 0;
    tick();
    chk("t4_grant_e1", 32'(grant_val_o), 1);
    tick();
    chk("t4_grant_e2", 32'(grant_val_o), 1);
    tick();
    chk("t4_grant_e3", 32'(grant_val_o), 0);
    chk("t4_no_busy", 32'(busy_cycles), 0);
`endif

    // 5: reset in the middle of DRAIN
    wait_idle();
    raise(3, 16'h5A5A, 4'd0);
    wait_ready();
    chk("t5_ready", 32'(req_ready_o), 32'h8);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_in_drain", 32'(grant_val_o), 1);
    raise(0, 16'h0F0F, 4'd3);
    raise(3, 16'h3333, 4'd3);
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    chk_all_zero("t5_rst");
    wait_ready();
    chk("t5_first_after_rst", 32'(req_ready_o), 32'h1);
    wait_ready();
    chk("t5_second_after_rst", 32'(req_ready_o), 32'h8);

    // 6: random traffic
    wait_idle();
    exp_q.delete();
    got_q.delete();
    acc0 = accepts;
    for (int k = 0; k < 100; k++) begin
      int c = int'($urandom_range(0, 3));
      for (int i = 0; i < 500 && req_val_i[c]; i++) tick();
      raise(c, 16'($urandom), 4'($urandom_range(0, 15)));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end
    wait_idle();
    chk("t6_accepts", 32'(accepts - acc0), 100);
    chk("t6_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("t6_word%0d", i), 32'(got_q[i].word), 32'(exp_q[i].word));
      chk($sformatf("t6_nbits%0d", i), 32'(got_q[i].n), 32'(exp_q[i].n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
